// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the RAM access controller: RAM OP codes, access sizes,
// FSM states and requester IDs.
package mem_ctrl_pkg;

   localparam logic [5:0] OP_RD_BYTE = 6'b000001;
   localparam logic [5:0] OP_RD_HALF = 6'b000010;
   localparam logic [5:0] OP_RD_WORD = 6'b001000;
   localparam logic [5:0] OP_WR_BYTE = 6'b000101;
   localparam logic [5:0] OP_WR_HALF = 6'b000110;
   localparam logic [5:0] OP_WR_WORD = 6'b000100;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_BAD  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUS,
      ST_DONE
   } state_t;

   localparam int REQ_FETCH = 0;
   localparam int REQ_DATA  = 1;

   function automatic logic [5:0] op_code(input logic rw, input logic [1:0] size);
      case (size)
         SZ_BYTE: return rw ? OP_RD_BYTE : OP_WR_BYTE;
         SZ_HALF: return rw ? OP_RD_HALF : OP_WR_HALF;
         default: return rw ? OP_RD_WORD : OP_WR_WORD;
      endcase
   endfunction

   // Read data is right-justified by the RAM; clear the bytes outside the access.
   function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] d);
      case (size)
         SZ_BYTE: return {24'b0, d[7:0]};
         SZ_HALF: return {16'b0, d[15:0]};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin arbiter: on a tie, grants the requester not granted last.
// last_grant advances only when the controller takes the grant.
module mem_rr_arb
   import mem_ctrl_pkg::*;
(
   input  logic       CLK,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       take,
   output logic [1:0] gnt
);

   logic last_grant;  // 1 = data was granted last

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      gnt = 2'b00;
      case (req)
         2'b01:   gnt[REQ_FETCH] = 1'b1;
         2'b10:   gnt[REQ_DATA]  = 1'b1;
         2'b11:   if (last_grant) gnt[REQ_FETCH] = 1'b1;
                  else            gnt[REQ_DATA]  = 1'b1;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset)    last_grant <= 1'b1;
      else if (take) last_grant <= gnt[REQ_DATA];
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between the fetch/load-store requesters and the byte-addressed RAM:
// arbitrates, checks alignment, runs the Enable/MOC handshake with a timeout.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int AW      = 9
)
(
   input  logic          CLK,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [31:0]   if_rdata,
   output logic          if_err,
   input  logic          d_req,
   input  logic          d_rw,
   input  logic [1:0]    d_size,
   input  logic [AW-1:0] d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_ack,
   output logic [31:0]   d_rdata,
   output logic          d_err,
   output logic          mem_enable,
   output logic          mem_rw,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_datain,
   output logic [5:0]    mem_op,
   input  logic [31:0]   mem_dataout,
   input  logic          mem_moc,
   output logic          busy
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t        state, state_n;
   logic [1:0]    gnt;
   logic          take, sel_data, grant_err, timed_out;
   logic          start, fin, fin_owner, fin_err;
   logic [31:0]   fin_data;
   logic          owner;  // 1 = data requester owns the bus access
   logic [1:0]    cur_size;
   logic [CW-1:0] wait_cnt;

   mem_rr_arb u_arb (
      .CLK   (CLK),
      .reset (reset),
      .req   ({d_req, if_req}),
      .take  (take),
      .gnt   (gnt)
   );

   assign sel_data  = gnt[REQ_DATA];
   assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));
   assign busy      = (state != ST_IDLE);

   always_comb begin
      grant_err = 1'b0;
      if (sel_data)
         grant_err = (d_size == SZ_BAD)
                  || (d_size == SZ_HALF && d_addr[0])
                  || (d_size == SZ_WORD && d_addr[1:0] != 2'b00);
      else
         grant_err = (if_addr[1:0] != 2'b00);
   end

   always_comb begin
      state_n   = state;
      take      = 1'b0;
      start     = 1'b0;
      fin       = 1'b0;
      fin_owner = owner;
      fin_err   = 1'b0;
      fin_data  = '0;
      case (state)
         ST_IDLE: if (|gnt) begin
            take      = 1'b1;
            fin_owner = sel_data;
            if (grant_err) begin
               fin     = 1'b1;
               fin_err = 1'b1;
               state_n = ST_DONE;
            end else begin
               start   = 1'b1;
               state_n = ST_BUS;
            end
         end
         // MOC on the timeout edge still counts as a normal completion.
         ST_BUS: if (mem_moc || timed_out) begin
            fin      = 1'b1;
            fin_err  = !mem_moc;
            fin_data = (mem_moc && mem_rw) ? size_mask(cur_size, mem_dataout) : '0;
            state_n  = ST_DONE;
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_ff @(posedge CLK or negedge reset) begin
      // NOTE: every output register is cleared by reset so an aborted access leaves nothing driven.
      if (!reset) begin
         if_ack     <= 1'b0;
         if_err     <= 1'b0;
         if_rdata   <= '0;
         d_ack      <= 1'b0;
         d_err      <= 1'b0;
         d_rdata    <= '0;
         mem_enable <= 1'b0;
         mem_rw     <= 1'b0;
         mem_addr   <= '0;
         mem_datain <= '0;
         mem_op     <= '0;
         owner      <= 1'b0;
         cur_size   <= SZ_BYTE;
         wait_cnt   <= '0;
      end else begin
         if_ack <= fin && !fin_owner;
         d_ack  <= fin &&  fin_owner;
         if_err <= fin && !fin_owner && fin_err;
         d_err  <= fin &&  fin_owner && fin_err;
         if (fin && !fin_owner) if_rdata <= fin_data;
         if (fin &&  fin_owner) d_rdata  <= fin_data;

         if (start) begin
            mem_enable <= 1'b1;
            owner      <= sel_data;
            cur_size   <= sel_data ? d_size : SZ_WORD;
            mem_addr   <= sel_data ? d_addr : if_addr;
            mem_rw     <= sel_data ? d_rw : 1'b1;
            mem_op     <= sel_data ? op_code(d_rw, d_size) : OP_RD_WORD;
            mem_datain <= sel_data ? d_wdata : '0;
            wait_cnt   <= '0;
         end else if (fin) begin
            mem_enable <= 1'b0;
         end else if (state == ST_BUS && !mem_moc) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end

endmodule
